// File: rtl/memory_port_arbiter.sv
// Arbitrates one single-port, fixed-latency memory between instruction fetch and the MEM stage.
// Data has fixed priority; each access walks IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE.
module memory_port_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  fetchReq,
    input  logic [ADDR_WIDTH-1:0] fetchAddress,
    input  logic                  fetchFlush,
    output logic                  fetchReady,
    output logic [DATA_WIDTH-1:0] fetchData,
    output logic                  fetchStall,
    input  logic                  dataReq,
    input  logic                  dataWrite,
    input  logic [ADDR_WIDTH-1:0] dataAddress,
    input  logic [DATA_WIDTH-1:0] dataWriteData,
    output logic                  dataReady,
    output logic [DATA_WIDTH-1:0] dataReadData,
    output logic                  dataStall,
    output logic                  memEnable,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    input  logic [DATA_WIDTH-1:0] memReadData
);

    localparam int unsigned CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    owner_data_q, owner_data_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    kill_q, kill_d;
    logic [DATA_WIDTH-1:0]   fetch_data_q, fetch_data_d;
    logic [DATA_WIDTH-1:0]   data_rdata_q, data_rdata_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= S_IDLE;
            owner_data_q <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            kill_q       <= 1'b0;
            fetch_data_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_data_q <= owner_data_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            kill_q       <= kill_d;
            fetch_data_q <= fetch_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_data_d = owner_data_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        kill_d       = kill_q;
        fetch_data_d = fetch_data_q;
        data_rdata_d = data_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (dataReq) begin
                    owner_data_d = 1'b1;
                    write_d      = dataWrite;
                    addr_d       = dataAddress;
                    wdata_d      = dataWriteData;
                    state_d      = S_ISSUE;
                end else if (fetchReq && !fetchFlush) begin
                    owner_data_d = 1'b0;
                    write_d      = 1'b0;
                    addr_d       = fetchAddress;
                    wdata_d      = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!owner_data_q && fetchFlush) kill_d = 1'b1;
                if (write_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CW'(MEM_LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!owner_data_q && fetchFlush) kill_d = 1'b1;
                if (cnt_q == '0) begin
                    // Read data is captured straight into the output registers so it is
                    // already valid during the DONE cycle; a killed fetch leaves fetchData untouched.
                    if (owner_data_q) begin
                        data_rdata_d = memReadData;
                    end else if (!(kill_q || fetchFlush)) begin
                        fetch_data_d = memReadData;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign memEnable    = (state_q == S_ISSUE);
    assign memWrite     = (state_q == S_ISSUE) && write_q;
    assign memAddress   = (state_q == S_ISSUE) ? addr_q  : '0;
    assign memWriteData = (state_q == S_ISSUE) ? wdata_q : '0;

    assign fetchReady   = (state_q == S_DONE) && !owner_data_q && !kill_q;
    assign dataReady    = (state_q == S_DONE) && owner_data_q;
    assign fetchData    = fetch_data_q;
    assign dataReadData = data_rdata_q;
    assign fetchStall   = fetchReq & ~fetchReady;
    assign dataStall    = dataReq & ~dataReady;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter with MEM_LATENCY=2; hand-computed cycle-by-cycle expectations.
module tb_memory_port_arbiter;

    logic        clk;
    logic        resetN;
    logic        fetchReq;
    logic [31:0] fetchAddress;
    logic        fetchFlush;
    logic        fetchReady;
    logic [31:0] fetchData;
    logic        fetchStall;
    logic        dataReq;
    logic        dataWrite;
    logic [31:0] dataAddress;
    logic [31:0] dataWriteData;
    logic        dataReady;
    logic [31:0] dataReadData;
    logic        dataStall;
    logic        memEnable;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;

    int errors = 0;
    int checks = 0;

    memory_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_LATENCY(2)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .fetchReq     (fetchReq),
        .fetchAddress (fetchAddress),
        .fetchFlush   (fetchFlush),
        .fetchReady   (fetchReady),
        .fetchData    (fetchData),
        .fetchStall   (fetchStall),
        .dataReq      (dataReq),
        .dataWrite    (dataWrite),
        .dataAddress  (dataAddress),
        .dataWriteData(dataWriteData),
        .dataReady    (dataReady),
        .dataReadData (dataReadData),
        .dataStall    (dataStall),
        .memEnable    (memEnable),
        .memWrite     (memWrite),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memReadData  (memReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 time units after a rising edge; checks run 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        resetN        = 1'b0;
        fetchReq      = 1'b0;
        fetchAddress  = '0;
        fetchFlush    = 1'b0;
        dataReq       = 1'b0;
        dataWrite     = 1'b0;
        dataAddress   = '0;
        dataWriteData = '0;
        memReadData   = '0;
        next_cycle();
        next_cycle();
        settle();
        check("rst_memEnable", 32'(memEnable), 32'd0);
        check("rst_fetchReady", 32'(fetchReady), 32'd0);
        check("rst_dataReady", 32'(dataReady), 32'd0);
        check("rst_fetchData", fetchData, 32'h0);
        check("rst_memAddress", memAddress, 32'h0);
        next_cycle();
        resetN = 1'b1;
        next_cycle();

        // Lone fetch
        fetchReq = 1'b1; fetchAddress = 32'h10;
        settle();
        check("t1_c0_stall", 32'(fetchStall), 32'd1);
        check("t1_c0_en", 32'(memEnable), 32'd0);
        next_cycle(); settle();
        check("t1_c1_en", 32'(memEnable), 32'd1);
        check("t1_c1_addr", memAddress, 32'h10);
        check("t1_c1_wr", 32'(memWrite), 32'd0);
        next_cycle(); settle();
        check("t1_c2_en", 32'(memEnable), 32'd0);
        check("t1_c2_addr", memAddress, 32'h0);
        check("t1_c2_stall", 32'(fetchStall), 32'd1);
        next_cycle();
        memReadData = 32'hDEADBEEF;
        settle();
        check("t1_c3_rdy", 32'(fetchReady), 32'd0);
        check("t1_c3_stall", 32'(fetchStall), 32'd1);
        next_cycle();
        memReadData = 32'h0;
        settle();
        check("t1_c4_rdy", 32'(fetchReady), 32'd1);
        check("t1_c4_data", fetchData, 32'hDEADBEEF);
        check("t1_c4_stall", 32'(fetchStall), 32'd0);
        next_cycle();
        fetchReq = 1'b0;
        settle();
        check("t1_c5_rdy", 32'(fetchReady), 32'd0);
        check("t1_c5_hold", fetchData, 32'hDEADBEEF);

        // Conflict: data read wins, fetch follows after the mandatory IDLE
        next_cycle();
        fetchReq = 1'b1; fetchAddress = 32'h20;
        dataReq = 1'b1; dataWrite = 1'b0; dataAddress = 32'h80;
        settle();
        check("t2_c0_en", 32'(memEnable), 32'd0);
        next_cycle(); settle();
        check("t2_c1_en", 32'(memEnable), 32'd1);
        check("t2_c1_addr", memAddress, 32'h80);
        next_cycle();
        next_cycle();
        memReadData = 32'hA5A50001;
        settle();
        check("t2_c3_drdy", 32'(dataReady), 32'd0);
        next_cycle();
        memReadData = 32'h0;
        settle();
        check("t2_c4_drdy", 32'(dataReady), 32'd1);
        check("t2_c4_ddata", dataReadData, 32'hA5A50001);
        check("t2_c4_frdy", 32'(fetchReady), 32'd0);
        check("t2_c4_fstall", 32'(fetchStall), 32'd1);
        check("t2_c4_dstall", 32'(dataStall), 32'd0);
        next_cycle();
        dataReq = 1'b0;
        settle();
        check("t2_c5_en", 32'(memEnable), 32'd0);
        next_cycle(); settle();
        check("t2_c6_en", 32'(memEnable), 32'd1);
        check("t2_c6_addr", memAddress, 32'h20);
        next_cycle();
        next_cycle();
        memReadData = 32'h0BADF00D;
        next_cycle();
        memReadData = 32'h0;
        settle();
        check("t2_c9_frdy", 32'(fetchReady), 32'd1);
        check("t2_c9_fdata", fetchData, 32'h0BADF00D);
        check("t2_c9_ddata", dataReadData, 32'hA5A50001);
        next_cycle();
        fetchReq = 1'b0;

        // Write
        next_cycle();
        dataReq = 1'b1; dataWrite = 1'b1; dataAddress = 32'h40; dataWriteData = 32'h12345678;
        next_cycle(); settle();
        check("t3_c1_en", 32'(memEnable), 32'd1);
        check("t3_c1_wr", 32'(memWrite), 32'd1);
        check("t3_c1_addr", memAddress, 32'h40);
        check("t3_c1_wdata", memWriteData, 32'h12345678);
        next_cycle(); settle();
        check("t3_c2_drdy", 32'(dataReady), 32'd1);
        check("t3_c2_ddata", dataReadData, 32'hA5A50001);
        check("t3_c2_wr", 32'(memWrite), 32'd0);
        next_cycle();
        dataReq = 1'b0; dataWrite = 1'b0;
        settle();
        check("t3_c3_drdy", 32'(dataReady), 32'd0);
        check("t3_c3_wdata", memWriteData, 32'h0);

        // Flush of an in-flight fetch
        next_cycle();
        fetchReq = 1'b1; fetchAddress = 32'h30;
        next_cycle(); settle();
        check("t4_c1_en", 32'(memEnable), 32'd1);
        next_cycle();
        fetchFlush = 1'b1; fetchReq = 1'b0;
        next_cycle();
        fetchFlush = 1'b0; memReadData = 32'h11111111;
        next_cycle();
        memReadData = 32'h0;
        settle();
        check("t4_c4_frdy", 32'(fetchReady), 32'd0);
        check("t4_c4_fdata", fetchData, 32'h0BADF00D);
        // Flush in IDLE blocks the grant
        next_cycle();
        fetchReq = 1'b1; fetchAddress = 32'h34; fetchFlush = 1'b1;
        next_cycle();
        fetchFlush = 1'b0;
        settle();
        check("t4_c6_en", 32'(memEnable), 32'd0);
        next_cycle(); settle();
        check("t4_c7_en", 32'(memEnable), 32'd1);
        check("t4_c7_addr", memAddress, 32'h34);
        next_cycle();
        next_cycle();
        memReadData = 32'h22222222;
        next_cycle();
        memReadData = 32'h0;
        settle();
        check("t4_c10_frdy", 32'(fetchReady), 32'd1);
        check("t4_c10_fdata", fetchData, 32'h22222222);
        next_cycle();
        fetchReq = 1'b0;

        // Reset in the middle of a read
        next_cycle();
        fetchReq = 1'b1; fetchAddress = 32'h50;
        next_cycle(); settle();
        check("t5_c1_en", 32'(memEnable), 32'd1);
        next_cycle();
        resetN = 1'b0; fetchReq = 1'b0;
        settle();
        check("t5_rst_fdata", fetchData, 32'h0);
        check("t5_rst_ddata", dataReadData, 32'h0);
        check("t5_rst_en", 32'(memEnable), 32'd0);
        check("t5_rst_frdy", 32'(fetchReady), 32'd0);
        next_cycle();
        memReadData = 32'h99999999;
        settle();
        check("t5_rst2_frdy", 32'(fetchReady), 32'd0);
        next_cycle();
        resetN = 1'b1; memReadData = 32'h0;
        fetchReq = 1'b1; fetchAddress = 32'h60;
        settle();
        check("t5_rel_frdy", 32'(fetchReady), 32'd0);
        next_cycle(); settle();
        check("t5_c1_addr", memAddress, 32'h60);
        next_cycle();
        next_cycle();
        memReadData = 32'h33333333;
        next_cycle();
        memReadData = 32'h0;
        settle();
        check("t5_c4_frdy", 32'(fetchReady), 32'd1);
        check("t5_c4_fdata", fetchData, 32'h33333333);
        next_cycle();
        fetchReq = 1'b0;
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
